// File: rtl/seq_log2_pkg.sv
// Shared constants for the power-of-two generator / floor-log2 encoder pair.
// Widths live here so both stages stay matched.
package seq_log2_pkg;

  localparam int SEQ_WIDTH = 7;
  localparam int SEQ_LOGW  = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/seq_log2.sv
// Iterative floor-log2 encoder: shifts the captured value right until only
// bit 0 can remain, counting shifts and remembering any 1 that fell off.
module seq_log2
  import seq_log2_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int LOGW  = SEQ_LOGW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [LOGW-1:0]  log,
  output logic             onehot,
  output logic             zero,
  output logic [1:0]       state
);

  // Handshake: start (with din) is accepted on a rising edge only while
  // state is IDLE or DONE; busy stays high until the result edge, and done
  // is a one-cycle pulse during which log/onehot/zero are valid. They hold
  // afterwards until the next done. start while busy is dropped.

  logic [WIDTH-1:0] sr;
  logic [LOGW-1:0]  cnt;
  logic             drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sr     <= '0;
      cnt    <= '0;
      drop   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      log    <= '0;
      onehot <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sr    <= din;
            cnt   <= '0;
            drop  <= 1'b0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // Only bit 0 left: the count is the index of the top set bit.
          if (sr[WIDTH-1:1] == '0) begin
            log    <= cnt;
            zero   <= (sr == '0);
            onehot <= sr[0] && !drop;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            sr   <= sr >> 1;
            cnt  <= cnt + LOGW'(1);
            drop <= drop | sr[0];
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_log2.sv
// Self-checking bench for seq_log2: vector table, handshake/reset sequences,
// generator sweep and randomized operations against a arithmetic model.
module tb_seq_log2;
  import seq_log2_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] din;
  logic       busy;
  logic       done;
  logic [2:0] log;
  logic       onehot;
  logic       zero;
  logic [1:0] state;

  int vectors;
  int miscompares;

  seq_log2 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .log    (log),
    .onehot (onehot),
    .zero   (zero),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] d;
    int         exp_log;
    int         exp_onehot;
    int         exp_zero;
    int         exp_lat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: floor(log2) by repeated halving, one-hot by population count.
  function automatic int ref_log(input logic [6:0] d);
    int v;
    int lg;
    v  = int'(d);
    lg = 0;
    while (v > 1) begin
      v  = v / 2;
      lg = lg + 1;
    end
    return lg;
  endfunction

  function automatic logic [6:0] pow2_gen(input int a);
    logic [6:0] r;
    r = '0;
    if (a >= 0 && a < 7) r[a] = 1'b1;
    return r;
  endfunction

  // Present start for one edge; returns at the negedge after acceptance.
  task automatic launch(input logic [6:0] d);
    @(negedge clk);
    start = 1'b1;
    din   = d;
    @(negedge clk);
    start = 1'b0;
    din   = 7'($urandom);
  endtask

  // lat = edges after the accepting edge until done is seen.
  task automatic wait_done(input bit noise, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        din   = 7'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [6:0] d, input int lat, input int nbusy);
    int lg;
    lg = ref_log(d);
    chk({tag, "_lat"}, lat, lg + 1);
    chk({tag, "_busy_cycles"}, nbusy, lg + 1);
    chk({tag, "_log"}, int'(log), lg);
    chk({tag, "_onehot"}, int'(onehot), ($countones(d) == 1) ? 1 : 0);
    chk({tag, "_zero"}, int'(zero), (d == 7'd0) ? 1 : 0);
  endtask

  initial begin
    int lat;
    int nbusy;
    logic [6:0] d;

    vectors     = 0;
    miscompares = 0;
    start = 1'b0;
    din   = '0;
    rst_n = 1'b0;

    tbl[0] = '{7'h40, 6, 1, 0, 7};
    tbl[1] = '{7'h00, 0, 0, 1, 1};
    tbl[2] = '{7'h55, 6, 0, 0, 7};
    tbl[3] = '{7'h03, 1, 0, 0, 2};
    tbl[4] = '{7'h01, 0, 1, 0, 1};
    tbl[5] = '{7'h7f, 6, 0, 0, 7};
    tbl[6] = '{7'h02, 1, 1, 0, 2};

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_log", int'(log), 0);
    chk("rst_onehot", int'(onehot), 0);
    chk("rst_zero", int'(zero), 0);
    chk("rst_state", int'(state), int'(ST_IDLE));
    rst_n = 1'b1;

    // Table vectors with hand-derived expectations.
    for (int i = 0; i < 7; i++) begin
      launch(tbl[i].d);
      wait_done(1'b0, lat, nbusy);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_busy_cycles", i), nbusy, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_log", i), int'(log), tbl[i].exp_log);
      chk($sformatf("tbl%0d_onehot", i), int'(onehot), tbl[i].exp_onehot);
      chk($sformatf("tbl%0d_zero", i), int'(zero), tbl[i].exp_zero);
      @(negedge clk);
      chk($sformatf("tbl%0d_done_pulse", i), int'(done), 0);
      chk($sformatf("tbl%0d_idle", i), int'(state), int'(ST_IDLE));
      chk($sformatf("tbl%0d_log_hold", i), int'(log), tbl[i].exp_log);
    end

    // START while busy is ignored, then back-to-back start in the DONE cycle.
    launch(7'h40);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    din   = 7'h01;
    @(negedge clk);
    start = 1'b0;
    lat   = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ignore_lat", lat, 7);
    chk("ignore_log", int'(log), 6);
    chk("ignore_onehot", int'(onehot), 1);
    start = 1'b1;
    din   = 7'h04;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_done_low", int'(done), 0);
    wait_done(1'b0, lat, nbusy);
    chk("b2b_lat", lat, 3);
    chk("b2b_log", int'(log), 2);
    chk("b2b_onehot", int'(onehot), 1);
    chk("b2b_zero", int'(zero), 0);

    // Asynchronous reset in the middle of a shift.
    launch(7'h40);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_log", int'(log), 0);
    chk("arst_onehot", int'(onehot), 0);
    chk("arst_zero", int'(zero), 0);
    chk("arst_state", int'(state), int'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_after", int'(state), int'(ST_IDLE));
    launch(7'h08);
    wait_done(1'b0, lat, nbusy);
    check_result("post_rst", 7'h08, lat, nbusy);

    // Sweep the generator's exponent input through the full 7-bit range.
    for (int a = 0; a < 128; a++) begin
      d = pow2_gen(a);
      launch(d);
      wait_done(1'b0, lat, nbusy);
      check_result($sformatf("sweep%0d", a), d, lat, nbusy);
      if (a < 7) chk($sformatf("sweep%0d_exp", a), int'(log), a);
      else chk($sformatf("sweep%0d_zero_exp", a), int'(zero), 1);
    end

    // Random values with start noise during busy and occasional back-to-back.
    d = 7'($urandom);
    launch(d);
    for (int n = 0; n < 200; n++) begin
      wait_done(1'b1, lat, nbusy);
      check_result($sformatf("rnd%0d", n), d, lat, nbusy);
      d = 7'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1;
        din   = d;
        @(negedge clk);
        start = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        launch(d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
